hazard_forward_pc: RTL and testbench

// - Pipeline control slice for the 5-stage RV32 core: fetch PC register plus EX-stage operand forwarding.
// - Holds the fetch PC, which advances from the next-PC selection when enabled and freezes on stall.
// - Detects RAW hazards between EX source registers and MEM/WB destinations.
// - Muxes the forwarded values into both ALU operands.
// - Only the PC register is sequential; forwarding is purely combinational.

---
 rtl/hazard_forward_pc.sv | 94 +++++++++
 tb/tb_hazard_forward_pc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_pc.sv
// Fetch PC register plus EX-stage operand forwarding for a 5-stage RV32 pipeline.
// Only the PC is stateful; forward selects and operand muxes are combinational.
module hazard_forward_pc #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             writesregM,
  input  logic             writesregW,
  input  logic             alusrcimmE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic [WIDTH-1:0] srcM,
  input  logic [WIDTH-1:0] srcW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [WIDTH-1:0] srcaHazard,
  output logic [WIDTH-1:0] srcbHazard
);

  localparam logic [1:0] FwdEx  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  logic [WIDTH-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (pc_en) begin
      pc_q <= pc_next;
    end
  end

  assign pc = pc_q;

  logic hit_a_mem, hit_a_wb, hit_b_mem, hit_b_wb;

  // x0 is hardwired zero, so a write to it must never be forwarded.
  assign hit_a_mem = writesregM && (rdM != 5'd0) && (rdM == rs1E);
  assign hit_a_wb  = writesregW && (rdW != 5'd0) && (rdW == rs1E);
  assign hit_b_mem = writesregM && (rdM != 5'd0) && (rdM == rs2E);
  assign hit_b_wb  = writesregW && (rdW != 5'd0) && (rdW == rs2E);

  // MEM holds the younger producer, so it wins over WB.
  always_comb begin
    forwardAE = FwdEx;
    if (hit_a_mem) begin
      forwardAE = FwdMem;
    end else if (hit_a_wb) begin
      forwardAE = FwdWb;
    end
  end

  // An immediate operand B must never be replaced by a forwarded register value.
  always_comb begin
    forwardBE = FwdEx;
    if (!alusrcimmE) begin
      if (hit_b_mem) begin
        forwardBE = FwdMem;
      end else if (hit_b_wb) begin
        forwardBE = FwdWb;
      end
    end
  end

  // Reserved code 2'b11 falls through to the EX value.
  always_comb begin
    srcaHazard = srcaE;
    case (forwardAE)
      FwdMem:  srcaHazard = srcM;
      FwdWb:   srcaHazard = srcW;
      default: srcaHazard = srcaE;
    endcase
  end

  always_comb begin
    srcbHazard = srcbE;
    case (forwardBE)
      FwdMem:  srcbHazard = srcM;
      FwdWb:   srcbHazard = srcW;
      default: srcbHazard = srcbE;
    endcase
  end

endmodule

// File: tb/tb_hazard_forward_pc.sv
// Self-checking bench for hazard_forward_pc: directed cases plus randomized stimulus
// compared against a behavioural reference model.
module tb_hazard_forward_pc;

  localparam int unsigned      WIDTH    = 32;
  localparam logic [WIDTH-1:0] RESET_PC = 32'h0;

  logic             clk = 1'b0;
  logic             reset;
  logic             pc_en;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc;
  logic [4:0]       rs1E, rs2E, rdM, rdW;
  logic             writesregM, writesregW, alusrcimmE;
  logic [WIDTH-1:0] srcaE, srcbE, srcM, srcW;
  logic [1:0]       forwardAE, forwardBE;
  logic [WIDTH-1:0] srcaHazard, srcbHazard;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] pc_m;

  always #5 clk = ~clk;

  hazard_forward_pc #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_en     (pc_en),
    .pc_next   (pc_next),
    .pc        (pc),
    .rs1E      (rs1E),
    .rs2E      (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .writesregM(writesregM),
    .writesregW(writesregW),
    .alusrcimmE(alusrcimmE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .srcM      (srcM),
    .srcW      (srcW),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE),
    .srcaHazard(srcaHazard),
    .srcbHazard(srcbHazard)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Which producer supplies a source register: the youngest writer of a nonzero reg.
  function automatic logic [1:0] ref_sel(input logic [4:0] rs, input logic imm);
    if (imm || rs == 5'd0) return 2'b00;
    if (writesregM && rdM == rs) return 2'b10;
    if (writesregW && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [WIDTH-1:0] ref_val(input logic [4:0] rs, input logic imm,
                                               input logic [WIDTH-1:0] ex_val);
    if (imm || rs == 5'd0) return ex_val;
    if (writesregM && rdM == rs) return srcM;
    if (writesregW && rdW == rs) return srcW;
    return ex_val;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_fwdA"}, {30'd0, forwardAE}, {30'd0, ref_sel(rs1E, 1'b0)});
    check({tag, "_fwdB"}, {30'd0, forwardBE}, {30'd0, ref_sel(rs2E, alusrcimmE)});
    check({tag, "_srcA"}, srcaHazard, ref_val(rs1E, 1'b0, srcaE));
    check({tag, "_srcB"}, srcbHazard, ref_val(rs2E, alusrcimmE, srcbE));
  endtask

  task automatic clear_fwd();
    rs1E = 5'd0; rs2E = 5'd0; rdM = 5'd0; rdW = 5'd0;
    writesregM = 1'b0; writesregW = 1'b0; alusrcimmE = 1'b0;
    srcaE = 32'h99; srcbE = 32'h88; srcM = 32'h0; srcW = 32'h0;
  endtask

  initial begin
    reset = 1'b0; pc_en = 1'b0; pc_next = '0;
    clear_fwd();

    // PC reset, load and stall
    @(negedge clk);
    reset = 1'b1; pc_en = 1'b1; pc_next = 32'h40;
    @(negedge clk);
    check("pc_reset", pc, 32'h0);
    reset = 1'b0; pc_en = 1'b1; pc_next = 32'h4;
    @(negedge clk);
    check("pc_load", pc, 32'h4);
    pc_en = 1'b0; pc_next = 32'h8;
    @(negedge clk);
    check("pc_stall", pc, 32'h4);

    // MEM forward
    clear_fwd();
    rs1E = 5'd5; rdM = 5'd5; writesregM = 1'b1; srcM = 32'h11; srcaE = 32'h99;
    #1;
    check("mem_fwdA", {30'd0, forwardAE}, 32'd2);
    check("mem_srcA", srcaHazard, 32'h11);

    // MEM beats WB
    clear_fwd();
    rs2E = 5'd7; rdM = 5'd7; rdW = 5'd7; writesregM = 1'b1; writesregW = 1'b1;
    srcM = 32'hA; srcW = 32'hB;
    #1;
    check("prio_fwdB", {30'd0, forwardBE}, 32'd2);
    check("prio_srcB", srcbHazard, 32'hA);

    // WB forward
    clear_fwd();
    rs1E = 5'd3; rdM = 5'd4; rdW = 5'd3; writesregW = 1'b1; srcW = 32'h55;
    #1;
    check("wb_fwdA", {30'd0, forwardAE}, 32'd1);
    check("wb_srcA", srcaHazard, 32'h55);

    // x0 guard
    clear_fwd();
    rs1E = 5'd0; rdM = 5'd0; writesregM = 1'b1; srcM = 32'h77;
    #1;
    check("x0_fwdA", {30'd0, forwardAE}, 32'd0);
    check("x0_srcA", srcaHazard, 32'h99);

    // Immediate guard
    clear_fwd();
    rs2E = 5'd6; rdM = 5'd6; writesregM = 1'b1; alusrcimmE = 1'b1;
    srcbE = 32'h123; srcM = 32'hDEAD;
    #1;
    check("imm_fwdB", {30'd0, forwardBE}, 32'd0);
    check("imm_srcB", srcbHazard, 32'h123);

    // writesreg gating
    clear_fwd();
    rs1E = 5'd9; rdM = 5'd9; rdW = 5'd9; srcM = 32'h1; srcW = 32'h2;
    #1;
    check("gate_fwdA", {30'd0, forwardAE}, 32'd0);
    check("gate_srcA", srcaHazard, 32'h99);

    // Randomized PC and forwarding traffic
    pc_m = 32'h4;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check("pc_rand", pc, pc_m);
      reset   = ($urandom_range(0, 15) == 0);
      pc_en   = $urandom_range(0, 1) == 1;
      pc_next = $urandom;
      if (reset) pc_m = RESET_PC;
      else if (pc_en) pc_m = pc_next;

      if ($urandom_range(0, 3) == 0) begin
        rs1E = 5'($urandom); rs2E = 5'($urandom); rdM = 5'($urandom); rdW = 5'($urandom);
      end else begin
        rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
        rdM  = 5'($urandom_range(0, 3)); rdW  = 5'($urandom_range(0, 3));
      end
      writesregM = $urandom_range(0, 1) == 1;
      writesregW = $urandom_range(0, 1) == 1;
      alusrcimmE = $urandom_range(0, 3) == 0;
      srcaE = $urandom; srcbE = $urandom; srcM = $urandom; srcW = $urandom;
      #1;
      check_model("rand");
    end
    @(negedge clk);
    check("pc_final", pc, pc_m);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
